// File: rtl/matmul_pkg.sv
// -----------------------------------------------------------------------------
// matmul_pkg
// Shared definitions for the matrix-multiply core:
//   - element/word widths and element count
//   - controller state encoding
//   - the fixed 4x4 coefficient matrix A and a lookup helper
// -----------------------------------------------------------------------------
package matmul_pkg;

  localparam int DATA_W = 8;
  localparam int OUT_W  = 32;
  localparam int N_ELEM = 32;
  localparam int CNT_W  = 5;

  // Width of the raw adder-tree result: four 16-bit products summed.
  localparam int SUM_W  = 18;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_ELEM - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_READ,
    ST_DONE
  } state_e;

  // Coefficients stored so that A_COEF[i*4+m] = A[i][m]; the literal is
  // written MSB-first, hence the descending order.
  localparam logic [15:0][7:0] A_COEF = {
    8'd16, 8'd15, 8'd14, 8'd13,
    8'd12, 8'd11, 8'd10, 8'd9,
    8'd8,  8'd7,  8'd6,  8'd5,
    8'd4,  8'd3,  8'd2,  8'd1
  };

  function automatic logic [7:0] coef(input logic [1:0] row, input logic [1:0] col);
    return A_COEF[{row, col}];
  endfunction

endpackage

// File: rtl/matmul_res_mem.sv
// -----------------------------------------------------------------------------
// matmul_res_mem
// 32 x 32-bit result store. Writes are synchronous, reads are combinational
// so the controller can register the read word into its output stage.
//   clk    in   system clock, rising edge
//   we     in   write enable
//   waddr  in   write address (0..31)
//   wdata  in   write data
//   raddr  in   read address (0..31)
//   rdata  out  word at raddr
// Contents are not reset; every word is rewritten before it is read.
// -----------------------------------------------------------------------------
module matmul_res_mem
  import matmul_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [CNT_W-1:0] waddr,
  input  logic [OUT_W-1:0] wdata,
  input  logic [CNT_W-1:0] raddr,
  output logic [OUT_W-1:0] rdata
);

  logic [OUT_W-1:0] mem_q [N_ELEM];

  // Storage array, written one word per cycle during the compute phase.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/matmul_core.sv
// -----------------------------------------------------------------------------
// matmul_core
// Computes P = A * X where A is a fixed 4x4 coefficient matrix and X is a 4x8
// byte matrix streamed in column-major order (byte k -> X[k%4][k/4]).
// Results are written to an internal memory one per cycle, then streamed out.
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   start_in     in   start request, honoured only in IDLE/DONE
//   valid_input  in   X_load holds a valid byte this cycle (LOAD only)
//   X_load       in   X byte stream
//   cs_n         out  active-low result-memory select (COMPUTE/READ)
//   ry           out  read_data valid strobe
//   read_data    out  result word, zero when ry=0
//   finish       out  high once a matrix has been fully read out
// -----------------------------------------------------------------------------
module matmul_core
  import matmul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_in,
  input  logic              valid_input,
  input  logic [DATA_W-1:0] X_load,
  output logic              cs_n,
  output logic              ry,
  output logic [OUT_W-1:0]  read_data,
  output logic              finish
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cs_n_q, cs_n_d;
  logic             ry_q, ry_d;
  logic [OUT_W-1:0] read_data_q, read_data_d;
  logic             finish_q, finish_d;

  logic             x_we;
  logic [DATA_W-1:0] x_q [N_ELEM];

  logic             mem_we;
  logic [CNT_W-1:0] mem_raddr;
  logic [OUT_W-1:0] mem_rdata;
  logic [OUT_W-1:0] mac_word;

  logic [1:0]       row;
  logic [2:0]       col;
  logic [15:0]      prod [4];
  logic [SUM_W-1:0] sum;

  // The shared counter addresses X during LOAD and the result word during
  // COMPUTE/READ, so result address cnt = i*8+j splits directly into row/col.
  assign row = cnt_q[4:3];
  assign col = cnt_q[2:0];

  // Four parallel multipliers feeding a flat adder tree. Column j of X sits at
  // byte indices j*4 .. j*4+3, which is just {col, m}.
  always_comb begin
    for (int m = 0; m < 4; m++) begin
      prod[m] = {8'b0, coef(row, 2'(m))} * {8'b0, x_q[{col, 2'(m)}]};
    end
    sum = ({2'b0, prod[0]} + {2'b0, prod[1]}) + ({2'b0, prod[2]} + {2'b0, prod[3]});
    mac_word = {{(OUT_W-SUM_W){1'b0}}, sum};
  end

  // In READ the output stage is loaded one word ahead of the counter; on the
  // COMPUTE->READ transition word 0 is fetched.
  assign mem_raddr = (state_q == ST_READ) ? (cnt_q + 5'd1) : '0;

  // Next-state and next-output logic for the controller.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cs_n_d      = cs_n_q;
    ry_d        = 1'b0;
    read_data_d = '0;
    finish_d    = finish_q;
    x_we        = 1'b0;
    mem_we      = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_in) begin
          state_d  = ST_LOAD;
          cnt_d    = '0;
          finish_d = 1'b0;
          cs_n_d   = 1'b1;
        end
      end

      ST_LOAD: begin
        if (valid_input) begin
          x_we = 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d = ST_COMPUTE;
            cnt_d   = '0;
            cs_n_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end

      ST_COMPUTE: begin
        mem_we = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d     = ST_READ;
          cnt_d       = '0;
          ry_d        = 1'b1;
          read_data_d = mem_rdata;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      ST_READ: begin
        if (cnt_q == LAST_IDX) begin
          state_d  = ST_DONE;
          cnt_d    = '0;
          cs_n_d   = 1'b1;
          finish_d = 1'b1;
        end else begin
          cnt_d       = cnt_q + 5'd1;
          ry_d        = 1'b1;
          read_data_d = mem_rdata;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        cs_n_d  = 1'b1;
      end
    endcase
  end

  // Controller state and registered outputs; reset aborts any matrix at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cs_n_q      <= 1'b1;
      ry_q        <= 1'b0;
      read_data_q <= '0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cs_n_q      <= cs_n_d;
      ry_q        <= ry_d;
      read_data_q <= read_data_d;
      finish_q    <= finish_d;
    end
  end

  // X register file; contents only matter after a full load, so no reset.
  always_ff @(posedge clk) begin
    if (x_we) begin
      x_q[cnt_q] <= X_load;
    end
  end

  matmul_res_mem u_res_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (cnt_q),
    .wdata (mac_word),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  assign cs_n      = cs_n_q;
  assign ry        = ry_q;
  assign read_data = read_data_q;
  assign finish    = finish_q;

endmodule

// File: tb/tb_matmul_core.sv
// -----------------------------------------------------------------------------
// tb_matmul_core
// Self-checking bench for matmul_core: table of matrix patterns with spot
// result constants, a scoreboard queue of reference words checked against
// every ry beat, plus hand-written back-to-back and mid-READ reset sequences.
// -----------------------------------------------------------------------------
module tb_matmul_core;

  logic        clk;
  logic        rst;
  logic        start_in;
  logic        valid_input;
  logic [7:0]  X_load;
  logic        cs_n;
  logic        ry;
  logic [31:0] read_data;
  logic        finish;

  int checks;
  int failures;
  int cyc;
  int last_cyc;
  int first_ry_cyc;
  int got_idx;
  logic [31:0] got [32];
  logic [7:0]  x_pat [32];
  logic [31:0] exp_q [$];

  typedef struct {
    int pattern;   // 0 ones, 1 k, 2 all 255, 3 random
    bit gapped;
    int exp_w0;    // -1 = no spot constant
    int exp_w8;
    int exp_w31;
  } vec_t;

  vec_t vecs [5];

  matmul_core dut (
    .clk         (clk),
    .rst         (rst),
    .start_in    (start_in),
    .valid_input (valid_input),
    .X_load      (X_load),
    .cs_n        (cs_n),
    .ry          (ry),
    .read_data   (read_data),
    .finish      (finish)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used for latency measurements.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Generic comparison with failure reporting.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s got=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Reference: P[i][j] = sum_m A[i][m]*X[m][j], A[i][m] = 4*i+m+1, X[m][j] = byte j*4+m.
  function automatic logic [31:0] refWord(input int addr);
    int i, j, s;
    i = addr / 8;
    j = addr % 8;
    s = 0;
    for (int m = 0; m < 4; m++) s += (4 * i + m + 1) * int'(x_pat[j * 4 + m]);
    return 32'(s);
  endfunction

  // Output monitor: every ry beat is popped against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (ry) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_ry", 32'd1, 32'd0);
        end else begin
          checkOutput($sformatf("word%0d", got_idx), read_data, exp_q.pop_front());
          if (got_idx == 0) first_ry_cyc = cyc;
          if (got_idx < 32) got[got_idx] = read_data;
          got_idx++;
        end
      end else begin
        checkOutput("read_data_idle_zero", read_data, 32'd0);
      end
    end
  end

  // Start a matrix, stream 32 bytes, then poke extra bytes and start_in
  // while the core is computing; both must be ignored.
  task automatic loadMatrix(input int pattern, input bit gapped);
    for (int k = 0; k < 32; k++) begin
      case (pattern)
        0:       x_pat[k] = 8'd1;
        1:       x_pat[k] = 8'(k);
        2:       x_pat[k] = 8'd255;
        default: x_pat[k] = 8'($urandom_range(0, 255));
      endcase
    end
    got_idx = 0;
    @(posedge clk); #1 start_in = 1'b1;
    @(posedge clk); #1 start_in = 1'b0;
    checkOutput("finish_cleared_in_load", {31'b0, finish}, 32'd0);
    checkOutput("cs_n_in_load", {31'b0, cs_n}, 32'd1);
    for (int k = 0; k < 32; k++) begin
      if (gapped && k > 0) begin
        valid_input = 1'b0;
        X_load = 8'hEE;
        @(posedge clk); #1;
      end
      valid_input = 1'b1;
      X_load = x_pat[k];
      if (k == 31) begin
        last_cyc = cyc;
        for (int a = 0; a < 32; a++) exp_q.push_back(refWord(a));
      end
      @(posedge clk); #1;
    end
    X_load = 8'hAA;
    repeat (3) begin @(posedge clk); #1; end
    valid_input = 1'b0;
    start_in = 1'b1;
    @(posedge clk); #1 start_in = 1'b0;
    checkOutput("cs_n_in_compute", {31'b0, cs_n}, 32'd0);
    checkOutput("ry_low_in_compute", {31'b0, ry}, 32'd0);
  endtask

  // Wait (bounded) for finish and check latencies and the DONE outputs.
  task automatic waitDone();
    int n;
    n = 0;
    while (!finish && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("finish_seen", {31'b0, finish}, 32'd1);
    checkOutput("word_count", 32'(got_idx), 32'd32);
    checkOutput("latency_first_ry", 32'(first_ry_cyc - last_cyc), 32'd33);
    checkOutput("ry_to_finish", 32'(cyc - first_ry_cyc), 32'd32);
    checkOutput("cs_n_in_done", {31'b0, cs_n}, 32'd1);
  endtask

  // One table vector: full matrix, spot constants, finish held 3 cycles.
  task automatic applyStimulus(input vec_t v);
    loadMatrix(v.pattern, v.gapped);
    waitDone();
    if (v.exp_w0 >= 0) begin
      checkOutput("tbl_w0", got[0], 32'(v.exp_w0));
      checkOutput("tbl_w8", got[8], 32'(v.exp_w8));
      checkOutput("tbl_w31", got[31], 32'(v.exp_w31));
    end
    repeat (3) begin
      @(negedge clk);
      checkOutput("finish_held", {31'b0, finish}, 32'd1);
    end
  endtask

  initial begin
    int n;
    checks = 0;
    failures = 0;
    got_idx = 0;
    first_ry_cyc = 0;
    last_cyc = 0;
    rst = 1'b0;
    start_in = 1'b0;
    valid_input = 1'b0;
    X_load = 8'h00;

    vecs[0] = '{0, 1'b0, 10, 26, 58};
    vecs[1] = '{1, 1'b0, 20, 44, 1716};
    vecs[2] = '{0, 1'b1, 10, 26, 58};
    vecs[3] = '{2, 1'b0, 2550, 6630, 14790};
    vecs[4] = '{3, 1'b1, -1, -1, -1};

    // Reset values.
    repeat (3) @(negedge clk);
    checkOutput("rst_cs_n", {31'b0, cs_n}, 32'd1);
    checkOutput("rst_ry", {31'b0, ry}, 32'd0);
    checkOutput("rst_finish", {31'b0, finish}, 32'd0);
    checkOutput("rst_read_data", read_data, 32'd0);
    rst = 1'b1;

    // Table vectors; 2 -> 3 is the back-to-back case (all 255 after finish).
    for (int i = 0; i < 5; i++) begin
      $display("[TB] vector %0d pattern=%0d gapped=%0d", i, vecs[i].pattern, vecs[i].gapped);
      applyStimulus(vecs[i]);
    end

    // Reset in the middle of READ.
    $display("[TB] mid-READ reset");
    loadMatrix(1, 1'b0);
    n = 0;
    while (got_idx < 10 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reached_read", {31'b0, ry}, 32'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("abort_cs_n", {31'b0, cs_n}, 32'd1);
    checkOutput("abort_ry", {31'b0, ry}, 32'd0);
    checkOutput("abort_read_data", read_data, 32'd0);
    checkOutput("abort_finish", {31'b0, finish}, 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;

    applyStimulus('{3, 1'b0, -1, -1, -1});
    applyStimulus('{1, 1'b0, 20, 44, 1716});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard against a hung run.
  initial begin
    #500000;
    $display("[TB] FAIL timeout got=0 expected=1");
    $fatal(1, "[TB] timeout");
  end

endmodule
